// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle controller
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;
  typedef enum logic [3:0] {
    CL_ALU, CL_LOAD, CL_LUI, CL_STORE, CL_BR, CL_J, CL_JAL, CL_JR, CL_ILL
  } class_e;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_NOR  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_PASS = 3'd6;
  localparam logic [1:0] PC_INC4 = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;
  localparam logic [1:0] PC_REG  = 2'd3;
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;
  localparam logic [5:0] OP_ADDI = 6'd6;
  localparam logic [5:0] OP_SUBI = 6'd7;
  localparam logic [5:0] OP_ANDI = 6'd8;
  localparam logic [5:0] OP_ORI  = 6'd9;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LB   = 6'd11;
  localparam logic [5:0] OP_LW   = 6'd13;
  localparam logic [5:0] OP_LUI  = 6'd14;
  localparam logic [5:0] OP_SW   = 6'd17;
  localparam logic [5:0] OP_BGEZ = 6'd20;
  localparam logic [5:0] OP_J    = 6'd21;
  localparam logic [5:0] OP_JAL  = 6'd22;
  localparam logic [5:0] OP_JR   = 6'd23;
  typedef struct packed {
    logic       ir_load;
    logic       pc_inc;
    logic       pc_write;
    logic       br_en;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] byte_idx;
    logic       reg_write;
    logic       link_r31;
    logic [1:0] wd_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_out_t;
  // byte/half/word loads and stores share low opcode bits 11/00/01
  function automatic logic [1:0] size_last(input logic [1:0] lo);
    return lo == 2'b11 ? 2'd0 : lo == 2'b00 ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: opcode to class, last byte index and alu_op
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output class_e     cls_o,
  output logic [1:0] last_o,
  output logic [2:0] alu_op_o,
  output logic       imm_o
);
  assign imm_o = opcode_i >= OP_ADDI && opcode_i <= OP_SW;
  always_comb begin
    cls_o = CL_ILL;
    last_o = 2'd0;
    alu_op_o = ALU_ADD;
    if (opcode_i < OP_ADDI) begin
      cls_o = CL_ALU;
      alu_op_o = opcode_i[2:0];
    end else if (opcode_i <= OP_SLTI) begin
      cls_o = CL_ALU;
      alu_op_o = opcode_i == OP_SUBI ? ALU_SUB : opcode_i == OP_ANDI ? ALU_AND :
                 opcode_i == OP_ORI ? ALU_OR : opcode_i == OP_SLTI ? ALU_SLT : ALU_ADD;
    end else if (opcode_i <= OP_LW) begin
      cls_o = CL_LOAD;
      last_o = size_last(opcode_i[1:0]);
    end else if (opcode_i == OP_LUI) begin
      cls_o = CL_LUI;
      alu_op_o = ALU_PASS;
    end else if (opcode_i <= OP_SW) begin
      cls_o = CL_STORE;
      last_o = size_last(opcode_i[1:0]);
    end else if (opcode_i <= OP_BGEZ) begin
      cls_o = CL_BR;
      alu_op_o = ALU_SUB;
    end else if (opcode_i == OP_J) begin
      cls_o = CL_J;
    end else if (opcode_i == OP_JAL) begin
      cls_o = CL_JAL;
    end else if (opcode_i == OP_JR) begin
      cls_o = CL_JR;
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: byte-serial fetch/decode/exec/mem/wb control FSM
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic       br_cond,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       alu_src_imm,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] byte_idx,
  output logic       reg_write,
  output logic       link_r31,
  output logic [1:0] wd_src,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);
  state_e     state_q, state_d, resume;
  logic [1:0] cnt_q, cnt_d, last;
  logic [5:0] op_q, op_d;
  ctrl_out_t  out_q, out_d;
  class_e     cls;
  logic [2:0] dec_alu;
  logic       dec_imm;
  // in DECODE the live opcode drives everything; afterwards the latched copy
  assign op_d = state_q == S_DECODE ? opcode : op_q;
  assign resume = run ? S_FETCH : S_IDLE;
  ctrl_decode u_dec (
    .opcode_i (op_d),
    .cls_o    (cls),
    .last_o   (last),
    .alu_op_o (dec_alu),
    .imm_o    (dec_imm)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= 2'd0;
      op_q <= 6'd0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      out_q <= out_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = 2'd0;
    case (state_q)
      S_IDLE:   state_d = resume;
      S_FETCH: begin
        state_d = cnt_q == 2'd3 ? S_DECODE : S_FETCH;
        cnt_d = cnt_q + 2'd1;
      end
      S_DECODE: state_d = cls != CL_ILL ? S_EXEC : HALT_ON_ILLEGAL ? S_HALT : resume;
      S_EXEC:   state_d = (cls == CL_ALU || cls == CL_LUI) ? S_WB :
                          (cls == CL_LOAD || cls == CL_STORE) ? S_MEM : resume;
      S_MEM: begin
        state_d = cnt_q != last ? S_MEM : cls == CL_LOAD ? S_WB : resume;
        cnt_d = cnt_q == last ? 2'd0 : cnt_q + 2'd1;
      end
      S_WB:     state_d = resume;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end
  // outputs are computed for the upcoming state and registered with it
  always_comb begin
    out_d = '0;
    out_d.ir_load = state_d == S_FETCH;
    out_d.pc_inc = state_d == S_DECODE;
    out_d.illegal = state_d == S_HALT;
    out_d.byte_idx = (state_d == S_FETCH || state_d == S_MEM) ? cnt_d : 2'd0;
    if (state_d inside {S_EXEC, S_MEM, S_WB}) begin
      out_d.alu_op = dec_alu;
      out_d.alu_src_imm = dec_imm;
    end
    if (state_d == S_EXEC) begin
      out_d.br_en = cls == CL_BR;
      out_d.pc_write = cls inside {CL_J, CL_JAL, CL_JR};
      out_d.pc_src = cls == CL_BR ? PC_BR : cls == CL_JR ? PC_REG :
                     (cls == CL_J || cls == CL_JAL) ? PC_JMP : PC_INC4;
      out_d.reg_write = cls == CL_JAL;
      out_d.link_r31 = cls == CL_JAL;
      out_d.wd_src = cls == CL_JAL ? WD_LINK : WD_ALU;
      out_d.instr_done = cls inside {CL_BR, CL_J, CL_JAL, CL_JR};
    end
    if (state_d == S_MEM) begin
      out_d.mem_read = cls == CL_LOAD;
      out_d.mem_write = cls == CL_STORE;
      out_d.instr_done = cls == CL_STORE && cnt_d == last;
    end
    if (state_d == S_WB) begin
      out_d.reg_write = 1'b1;
      out_d.wd_src = cls == CL_LOAD ? WD_MEM : WD_ALU;
      out_d.instr_done = 1'b1;
    end
  end
  assign ir_load = out_q.ir_load;
  assign pc_inc = out_q.pc_inc;
  // the comparator result only exists during EXEC, so it gates the registered branch enable
  assign pc_write = out_q.pc_write | (out_q.br_en & br_cond);
  assign pc_src = out_q.pc_src;
  assign alu_op = out_q.alu_op;
  assign alu_src_imm = out_q.alu_src_imm;
  assign mem_read = out_q.mem_read;
  assign mem_write = out_q.mem_write;
  assign byte_idx = out_q.byte_idx;
  assign reg_write = out_q.reg_write;
  assign link_r31 = out_q.link_r31;
  assign wd_src = out_q.wd_src;
  assign instr_done = out_q.instr_done |
                      (state_q == S_DECODE && cls == CL_ILL && !HALT_ON_ILLEGAL);
  assign illegal = out_q.illegal;
  assign state = state_q;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter HALT_ON_ILLEGAL, default 1; 1 = illegal opcode enters HALT, 0 = illegal opcode is a no-op.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port run  input  1  start/continue fetching; sampled in IDLE and on the last cycle of each instruction.
REQ-005 SHALL have port opcode  input  6  instruction[31:26] from the instruction register, valid from DECODE onward.
REQ-006 SHALL have port br_cond  input  1  datapath comparator result for the latched branch (eq/neq/gez), valid in EXEC.
REQ-007 SHALL have outputs ir_load(1), pc_inc(1), pc_write(1), pc_src(2), alu_op(3), alu_src_imm(1), mem_read(1), mem_write(1), byte_idx(2), reg_write(1), link_r31(1), wd_src(2), instr_done(1), illegal(1), state(3); all registered.

Function
REQ-008 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-009 IDLE: run=1 -> FETCH with byte_idx=0; else stay.
REQ-010 FETCH: 4 cycles, ir_load=1, byte_idx 0,1,2,3 (big-endian byte at pc+byte_idx); after byte 3 -> DECODE.
REQ-011 DECODE: 1 cycle, pc_inc=1 (pc+4); latch opcode internally; -> EXEC, or HALT when opcode>=24 and HALT_ON_ILLEGAL=1.
REQ-012 Opcode classes: 0-10 ALU, 11-13 load (lb/lh/lw), 14 lui, 15-17 store (sb/sh/sw), 18-20 branch (beq/bneq/bgez), 21 j, 22 jal, 23 jr.
REQ-013 alu_op encoding: ADD=0, SUB=1, AND=2, NOR=3, OR=4, SLT=5, PASS=6; opcodes 0-5 map directly, 6/7/8/9/10 -> ADD/SUB/AND/OR/SLT, loads/stores -> ADD, lui -> PASS, branches -> SUB.
REQ-014 alu_src_imm=1 in EXEC/MEM/WB for opcodes 6-17; 0 otherwise.
REQ-015 EXEC for ALU/lui/load -> WB (load -> MEM first); store -> MEM.
REQ-016 EXEC for branch: pc_write=br_cond, pc_src=1 (pc+4 + offset<<2); instruction completes.
REQ-017 EXEC for j: pc_write=1, pc_src=2; jr: pc_write=1, pc_src=3; jal: pc_write=1, pc_src=2, reg_write=1, link_r31=1, wd_src=2 (old pc+4); each completes.
REQ-018 MEM: n cycles, n=1/2/4 for byte/half/word; byte_idx 0..n-1 (little-endian, addr+byte_idx); mem_read=1 for loads, mem_write=1 for stores; store completes on last byte; load -> WB.
REQ-019 WB: 1 cycle, reg_write=1, wd_src=1 for loads else 0; completes.
REQ-020 Completion cycle SHALL assert instr_done=1 for exactly one cycle; next state FETCH if run=1, else IDLE.
REQ-021 Latency from first FETCH cycle: ALU/lui 7, load 7+n, store 6+n, branch/j/jal/jr 6, illegal no-op (HALT_ON_ILLEGAL=0) 5 cycles (DECODE completes).
REQ-022 HALT: illegal=1 held, all enables 0, exits only via rst.
REQ-023 All enables (ir_load, pc_inc, pc_write, mem_read, mem_write, reg_write, link_r31) SHALL be 0 in any state/class not listed above; at most one of mem_read/mem_write high.
REQ-024 state output encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
REQ-025 run deassertion mid-instruction SHALL not abort it; only sampled per REQ-004.

Reset
REQ-026 rst=1 SHALL force IDLE immediately (asynchronous), byte_idx=0, all enables/pc_src/alu_op/wd_src/instr_done/illegal=0, latched opcode=0.
REQ-027 rst asserted mid-FETCH/MEM SHALL abandon the instruction with no further write enables; first cycle after release is IDLE.

Structure
REQ-028 Shared package ctrl_pkg SHALL hold state enum, opcode constants, alu_op, pc_src and wd_src encodings.
REQ-029 Combinational sub-module ctrl_decode SHALL map opcode to class, byte count and alu_op.

Verification
REQ-030 rst release, run=1, opcode=0 (add) -> states 1,1,1,1,2,3,5; reg_write=1 only in WB; instr_done on cycle 7.
REQ-031 opcode=13 (lw) -> MEM 4 cycles, mem_read=1, byte_idx 0,1,2,3, WB wd_src=1; 11 cycles total.
REQ-032 opcode=18, br_cond=1 -> EXEC pc_write=1 pc_src=1; br_cond=0 -> pc_write=0; both 6 cycles.
REQ-033 opcode=22 (jal) -> EXEC pc_write=1, pc_src=2, reg_write=1, link_r31=1, wd_src=2.
REQ-034 opcode=16 (sh) with rst pulsed on 2nd MEM cycle -> mem_write drops immediately, state=0, no instr_done.
REQ-035 opcode=30, HALT_ON_ILLEGAL=1 -> state=6, illegal=1 held regardless of run until rst.
